// File: rtl/fifo_multi_in.sv
// Multi-port enqueue, single-port dequeue circular FIFO.
// Define FIFO_MULTI_IN_STATS_EN to build the drop_count/high_water statistics.

module fifo_multi_in_lane #(
    parameter int CW = 5
) (
    input  logic          en,
    input  logic [CW-1:0] free,
    input  logic [CW-1:0] prefix,
    output logic          ready,
    output logic          accept
);
    // A port fits if the free space exceeds the requests ranked ahead of it.
    assign ready  = free > prefix;
    assign accept = en & ready;
endmodule

module fifo_multi_in #(
    parameter int DWIDTH     = 32,
    parameter int QUEUE_SIZE = 16,
    parameter int NUM_IN     = 4,
    localparam int AW        = $clog2(QUEUE_SIZE),
    localparam int CW        = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        in_enque_en,
    input  logic [NUM_IN*DWIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic                     out_deque_en,
    output logic                     out_valid,
    output logic [DWIDTH-1:0]        out_data,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty,
    output logic [31:0]              drop_count,
    output logic [CW-1:0]            high_water
);
    logic [QUEUE_SIZE-1:0][DWIDTH-1:0] mem;
    logic [AW-1:0]                     head, tail;
    logic [CW-1:0]                     free, n_acc, count_next;
    logic [NUM_IN-1:0][CW-1:0]         prefix;
    logic [NUM_IN-1:0]                 accept;
    logic                              deq;

    assign free       = CW'(QUEUE_SIZE) - count;
    assign empty      = (count == '0);
    assign full       = (count == CW'(QUEUE_SIZE));
    assign out_valid  = ~empty;
    // Dequeued and reset slots are zeroed, so the head slot reads 0 when empty.
    assign out_data   = mem[head];
    assign deq        = out_deque_en & ~empty;
    assign count_next = count + n_acc - CW'(deq);

    always_comb begin
        prefix = '0;
        for (int i = 1; i < NUM_IN; i++)
            prefix[i] = prefix[i-1] + CW'(in_enque_en[i-1]);
    end

    always_comb begin
        n_acc = '0;
        for (int i = 0; i < NUM_IN; i++)
            n_acc = n_acc + CW'(accept[i]);
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
        fifo_multi_in_lane #(.CW(CW)) u_lane (
            .en     (in_enque_en[g]),
            .free   (free),
            .prefix (prefix[g]),
            .ready  (in_ready[g]),
            .accept (accept[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) begin
                mem[head] <= '0;
                head      <= head + AW'(1);
            end
            // Accepted ports form a prefix of the requesters, so prefix[i] is the slot offset.
            for (int i = 0; i < NUM_IN; i++)
                if (accept[i])
                    mem[tail + prefix[i][AW-1:0]] <= in_data[i*DWIDTH +: DWIDTH];
            tail  <= tail + n_acc[AW-1:0];
            count <= count_next;
        end
    end

`ifdef FIFO_MULTI_IN_STATS_EN
    logic [CW-1:0] n_drop;
    logic [32:0]   drop_sum;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_IN; i++)
            n_drop = n_drop + CW'(in_enque_en[i] & ~in_ready[i]);
    end

    assign drop_sum = {1'b0, drop_count} + 33'(n_drop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            high_water <= '0;
        end else begin
            drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            if (count_next > high_water)
                high_water <= count_next;
        end
    end
`else
    assign drop_count = '0;
    assign high_water = '0;
`endif
endmodule

// File: tb/tb_fifo_multi_in.sv
// Randomized bench for fifo_multi_in against a queue-based reference model,
// plus literal scenario checks.

module tb_fifo_multi_in;
    localparam int DW = 32, Q = 16, N = 4, CW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_enque_en, in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_deque_en, out_valid, full, empty;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     count, high_water;
    logic [31:0]       drop_count;

    fifo_multi_in #(.DWIDTH(DW), .QUEUE_SIZE(Q), .NUM_IN(N)) dut (
        .clk(clk), .rst(rst), .in_enque_en(in_enque_en), .in_data(in_data),
        .in_ready(in_ready), .out_deque_en(out_deque_en), .out_valid(out_valid),
        .out_data(out_data), .count(count), .full(full), .empty(empty),
        .drop_count(drop_count), .high_water(high_water)
    );

    always #5 clk = ~clk;

    int          vectors = 0, miscompares = 0;
    logic [DW-1:0] mq[$];
    longint      m_drop = 0;
    int          m_hw = 0;
`ifdef FIFO_MULTI_IN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] en);
        int k = 0;
        int fr = Q - mq.size();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = fr > k;
            if (en[i]) k++;
        end
        return r;
    endfunction

    task automatic model_step(input logic [N-1:0] en, input logic [N*DW-1:0] d, input logic deq);
        logic [DW-1:0] acc[$];
        int fr = Q - mq.size();
        int k = 0;
        for (int i = 0; i < N; i++)
            if (en[i]) begin
                if (fr > k) acc.push_back(d[i*DW +: DW]);
                else m_drop++;
                k++;
            end
        if (deq && mq.size() > 0) void'(mq.pop_front());
        foreach (acc[j]) mq.push_back(acc[j]);
        if (mq.size() > m_hw) m_hw = mq.size();
    endtask

    task automatic model_reset();
        mq.delete();
        m_drop = 0;
        m_hw = 0;
    endtask

    task automatic check_outputs();
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == Q);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("out_data", out_data, mq.size() != 0 ? mq[0] : '0);
        chk("drop_count", drop_count, STATS ? m_drop : 0);
        chk("high_water", high_water, STATS ? m_hw : 0);
    endtask

    // Called at a falling edge; compares, then advances one rising edge.
    task automatic cycle(input logic [N-1:0] en, input logic [N*DW-1:0] d, input logic deq);
        in_enque_en = en; in_data = d; out_deque_en = deq;
        #1;
        check_outputs();
        chk("in_ready", in_ready, model_ready(en));
        @(posedge clk);
        model_step(en, d, deq);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_enque_en = '0; in_data = '0; out_deque_en = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_ready", in_ready, 4'hF);
        rst = 1'b0;

        // Four-wide burst then ordered readout.
        cycle(4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
        chk("burst_count", count, 4);
        for (int k = 0; k < 4; k++) begin
            chk("burst_read", out_data, 32'hA0 + k);
            cycle('0, '0, 1'b1);
        end

        // Dequeue on empty is ignored; enqueue visible the next cycle.
        cycle(4'b0010, {32'h0, 32'h0, 32'h55, 32'h0}, 1'b1);
        chk("empty_deq_valid", out_valid, 1);
        chk("empty_deq_data", out_data, 32'h55);
        cycle('0, '0, 1'b1);

        // Burst straddling the wrap point (head=tail=14).
        do_reset();
        for (int k = 0; k < 14; k++) cycle(4'b0001, {96'h0, 32'(k)}, 1'b0);
        for (int k = 0; k < 14; k++) cycle('0, '0, 1'b1);
        cycle(4'hF, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b0);
        chk("wrap_count", count, 4);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_read", out_data, 32'hC0 + k);
            cycle('0, '0, 1'b1);
        end

        // count=14 with ports 0,2,3 requesting.
        cycle(4'hF, {32'h13, 32'h12, 32'h11, 32'h10}, 1'b0);
        cycle(4'hF, {32'h17, 32'h16, 32'h15, 32'h14}, 1'b0);
        cycle(4'hF, {32'h1B, 32'h1A, 32'h19, 32'h18}, 1'b0);
        cycle(4'b0011, {64'h0, 32'h1D, 32'h1C}, 1'b0);
        chk("c14_count", count, 14);
        in_enque_en = 4'b1101; #1;
        chk("c14_ready", in_ready, 4'b0111);
        cycle(4'b1101, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b0);
        chk("c14_full", full, 1);
        chk("c14_count16", count, 16);
        chk("c14_drop", drop_count, STATS ? 1 : 0);

        // Full with all ports requesting plus a dequeue.
        in_enque_en = 4'hF; out_deque_en = 1'b1; #1;
        chk("full_ready", in_ready, 4'b0000);
        cycle(4'hF, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b1);
        chk("full_count", count, 15);
        chk("full_drop", drop_count, STATS ? 5 : 0);

        // Random traffic: fill-heavy phase then drain-heavy phase.
        for (int k = 0; k < 400; k++) begin
            logic [N*DW-1:0] d;
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle(N'($urandom_range(0, 15)), d,
                  (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges.
        do_reset();
        cycle(4'hF, {32'h3, 32'h2, 32'h1, 32'h0}, 1'b0);
        cycle(4'hF, {32'h7, 32'h6, 32'h5, 32'h4}, 1'b0);
        cycle(4'h1, {96'h0, 32'h8}, 1'b0);
        chk("pre_rst_count", count, 9);
        #2 rst = 1'b1;
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_out_data", out_data, 0);
        chk("async_high_water", high_water, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle('0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_multi_in.md
FIFO_MULTI_IN -- requirements
Module: fifo_multi_in

Interface
REQ-001 Parameter DWIDTH, default 32, width of one data word.
REQ-002 Parameter QUEUE_SIZE, default 16, entry count; power of two, >= NUM_IN.
REQ-003 Parameter NUM_IN, default 4, number of enqueue ports; 1..QUEUE_SIZE.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_enque_en  input  NUM_IN  per-port enqueue request; bit i belongs to port i.
REQ-007 in_data  input  NUM_IN*DWIDTH  port i word at bits [i*DWIDTH +: DWIDTH].
REQ-008 in_ready  output  NUM_IN  port i is accepted this cycle when in_enque_en[i] and in_ready[i] are both 1.
REQ-009 out_deque_en  input  1  dequeue request.
REQ-010 out_valid  output  1  queue is non-empty; out_data holds the head word.
REQ-011 out_data  output  DWIDTH  head word; 0 when empty.
REQ-012 count  output  $clog2(QUEUE_SIZE)+1  number of stored entries, 0..QUEUE_SIZE.
REQ-013 full / empty  output  1 each  count==QUEUE_SIZE / count==0.
REQ-014 drop_count  output  32  stats: total rejected requests (see REQ-030).
REQ-015 high_water  output  $clog2(QUEUE_SIZE)+1  stats: maximum count since reset.

Function
REQ-016 Storage is a circular buffer with head and tail pointers of $clog2(QUEUE_SIZE) bits wrapping modulo QUEUE_SIZE; all QUEUE_SIZE entries are usable.
REQ-017 free = QUEUE_SIZE - count, taken from registered state at the start of the cycle; a same-cycle dequeue does not add space.
REQ-018 in_ready[i] = 1 iff free > (number of set in_enque_en bits with index < i); combinational; upstream must not derive in_enque_en from in_ready.
REQ-019 Accepted words are written at tail, tail+1, ... in ascending port index, skipping idle ports; tail advances by the number accepted (0..NUM_IN).
REQ-020 Ports with enque_en=1 and ready=0 are rejected; their words are discarded, with no retry or buffering.
REQ-021 Dequeue occurs when out_deque_en and out_valid are both 1; the head slot is cleared to 0 and head advances by 1.
REQ-022 Dequeue on empty is ignored; count does not underflow.
REQ-023 Simultaneous enqueue and dequeue: count_next = count + accepted - dequeued, in one cycle.
REQ-024 No bypass: a word enqueued into an empty queue appears on out_data the next cycle (enqueue-to-output latency 1).
REQ-025 Pointer wrap is seamless; a multi-word burst may straddle index QUEUE_SIZE-1 -> 0.
REQ-026 out_valid, out_data, count, full and empty are pure functions of registered state.

Reset
REQ-027 Reset forces head=0, tail=0, count=0 and all storage to 0, so out_valid=0, out_data=0, empty=1, full=0, and in_ready is all-ones if NUM_IN<=QUEUE_SIZE.
REQ-028 Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge; drop_count and high_water clear to 0.

Configuration
REQ-029 Macro FIFO_MULTI_IN_STATS_EN controls the statistics logic.
REQ-030 When the macro is defined, drop_count adds the number of rejected ports each cycle and saturates at 2^32-1; high_water updates to count_next whenever count_next exceeds it.
REQ-031 When the macro is undefined, drop_count and high_water are tied to 0, no stats registers exist, and the ports remain present.

Verification
REQ-032 Reset, then all 4 ports enabled with data 0xA0..0xA3 -> count=4 next cycle; dequeuing 4 times yields 0xA0, 0xA1, 0xA2, 0xA3.
REQ-033 count=14, ports 0,2,3 enabled -> in_ready=1,1,1,0; 0 and 2 are stored in order, port 3 is dropped; count=16, full=1; drop_count=1 (stats on).
REQ-034 tail=14, 4 ports enabled on empty-ish queue (head=14) -> words land at slots 14, 15, 0, 1; tail=2; FIFO order is preserved on readout.
REQ-035 full=1, all ports enabled, out_deque_en=1 -> in_ready=0000; one word leaves; count=15; drop_count increases by 4.
REQ-036 Empty queue, out_deque_en=1 with port 1 enabled (0x55) -> no dequeue that cycle; out_valid=1 and out_data=0x55 next cycle.
REQ-037 Fill to count=9, assert rst asynchronously between edges -> outputs immediately read count=0, empty=1, out_data=0, high_water=0.
